// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the pixel frame loader and its slot writer.
package loader_pkg;

    localparam int WIDTH_DEFAULT    = 3;
    localparam int HEIGHT_DEFAULT   = 3;
    localparam int PIX_BITS_DEFAULT = 8;
    localparam int N_DEFAULT        = WIDTH_DEFAULT * HEIGHT_DEFAULT;
    localparam int FW_DEFAULT       = N_DEFAULT * PIX_BITS_DEFAULT;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Index register width; never below one bit so a single-pixel frame still elaborates.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_slot_writer.sv
// Registered frame word: whole-word load plus a per-slot pixel write selected by index.
module frame_slot_writer
    import loader_pkg::*;
#(
    parameter int N        = N_DEFAULT,
    parameter int PIX_BITS = PIX_BITS_DEFAULT,
    parameter int IW       = idx_width(N)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [0:N*PIX_BITS-1] i_load_data,
    input  logic                  i_wr_en,
    input  logic [IW-1:0]         i_idx,
    input  logic [0:PIX_BITS-1]   i_pix,
    output logic [0:N*PIX_BITS-1] o_frame
);

    logic [0:N*PIX_BITS-1] r_frame;
    int                    w_base;

    assign w_base = int'(i_idx) * PIX_BITS;

    // A slot write issued on the same edge as a load lands on top of the loaded word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame <= '0;
        end else begin
            if (i_load) begin
                r_frame <= i_load_data;
            end
            if (i_wr_en) begin
                r_frame[w_base +: PIX_BITS] <= i_pix;
            end
        end
    end

    assign o_frame = r_frame;

endmodule

// File: rtl/pixel_frame_loader.sv
// Assembles a raster stream of pixels into one packed frame word with valid/ready on both sides.
// Define LOADER_DBUF_EN to add a separate fill buffer so filling overlaps the output hold.
module pixel_frame_loader
    import loader_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEFAULT,
    parameter int HEIGHT   = HEIGHT_DEFAULT,
    parameter int PIX_BITS = PIX_BITS_DEFAULT
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic [0:PIX_BITS-1]              pix_in,
    input  logic                             pix_sof,
    input  logic                             pix_valid,
    output logic                             pix_ready,
    output logic [0:WIDTH*HEIGHT*PIX_BITS-1] frame_out,
    output logic                             frame_valid,
    input  logic                             frame_ready,
    output logic                             sof_err,
    output logic [0:15]                      frame_cnt
);

    localparam int N  = WIDTH * HEIGHT;
    localparam int FW = N * PIX_BITS;
    localparam int IW = idx_width(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t        r_state, w_next_state;
    logic [IW-1:0] r_idx, w_next_idx, w_slot_idx;
    logic          r_pix_ready, r_frame_valid, r_sof_err;
    logic [0:15]   r_frame_cnt;
    logic          w_accept, w_deliver, w_resync, w_complete, w_out_load;

    assign w_accept   = pix_valid && r_pix_ready;
    assign w_deliver  = r_frame_valid && frame_ready;
    assign w_resync   = w_accept && pix_sof && (r_idx != '0);
    assign w_complete = w_accept && !w_resync && (r_idx == LAST_IDX);
    assign w_slot_idx = w_resync ? '0 : r_idx;

`ifdef LOADER_DBUF_EN
    logic [0:FW-1] w_fill_word;
    logic          w_out_free;

    assign w_out_free = !r_frame_valid || w_deliver;
    assign w_out_load = ((r_state == FILL) && w_complete && w_out_free) ||
                        ((r_state == HOLD) && w_deliver);

    frame_slot_writer #(.N(N), .PIX_BITS(PIX_BITS), .IW(IW)) u_fill (
        .clk         (clk),
        .rst         (rst),
        .i_load      (1'b0),
        .i_load_data ({FW{1'b0}}),
        .i_wr_en     (w_accept),
        .i_idx       (w_slot_idx),
        .i_pix       (pix_in),
        .o_frame     (w_fill_word)
    );

    // On the completing edge the fill word is not yet updated, so the last pixel is merged here.
    frame_slot_writer #(.N(N), .PIX_BITS(PIX_BITS), .IW(IW)) u_out (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_out_load),
        .i_load_data (w_fill_word),
        .i_wr_en     (w_out_load && w_complete),
        .i_idx       (w_slot_idx),
        .i_pix       (pix_in),
        .o_frame     (frame_out)
    );
`else
    assign w_out_load = w_complete;

    frame_slot_writer #(.N(N), .PIX_BITS(PIX_BITS), .IW(IW)) u_out (
        .clk         (clk),
        .rst         (rst),
        .i_load      (1'b0),
        .i_load_data ({FW{1'b0}}),
        .i_wr_en     (w_accept),
        .i_idx       (w_slot_idx),
        .i_pix       (pix_in),
        .o_frame     (frame_out)
    );
`endif

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        if (w_accept) begin
            if (w_resync) begin
                w_next_idx = IW'(1);
            end else if (w_complete) begin
                w_next_idx = '0;
            end else begin
                w_next_idx = r_idx + IW'(1);
            end
        end
        case (r_state)
            FILL: begin
                if (w_complete) begin
`ifdef LOADER_DBUF_EN
                    if (!w_out_free) begin
                        w_next_state = HOLD;
                    end
`else
                    w_next_state = HOLD;
`endif
                end
            end
            HOLD: begin
                if (w_deliver) begin
                    w_next_state = FILL;
                end
            end
            default: w_next_state = FILL;
        endcase
    end

    // pix_ready is registered so it only rises on the first edge after reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= FILL;
            r_idx         <= '0;
            r_pix_ready   <= 1'b0;
            r_frame_valid <= 1'b0;
            r_sof_err     <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_state     <= w_next_state;
            r_idx       <= w_next_idx;
            r_pix_ready <= (w_next_state == FILL);
            r_sof_err   <= w_resync;
            if (w_out_load) begin
                r_frame_valid <= 1'b1;
            end else if (w_deliver) begin
                r_frame_valid <= 1'b0;
            end
            if (w_deliver) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign pix_ready   = r_pix_ready;
    assign frame_valid = r_frame_valid;
    assign sof_err     = r_sof_err;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Scoreboard bench for pixel_frame_loader: a stream-level frame model feeds an expected-frame
// queue that a monitor drains on every delivery.
module tb_pixel_frame_loader;

    localparam int N = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:7]  pix_in = '0;
    logic        pix_sof = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [0:71] frame_out;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic        sof_err;
    logic [0:15] frame_cnt;

    int          checks = 0;
    int          failures = 0;
    logic [71:0] expQ[$];
    logic [71:0] modelFrame = '0;
    logic [71:0] lastFrame = '0;
    int          modelCnt = 0;
    int          expSofErr = 0;
    int          seenSofErr = 0;
    int          delivered = 0;
    int          stalls = 0;
    int          cyc = 0;
    int          deliverCyc[$];
    bit          monEn = 1'b0;
    bit          cntPending = 1'b0;
    bit          prevSof = 1'b0;
    bit          prevValid = 1'b0;
    bit          prevDeliver = 1'b0;
    bit          t6Phase = 1'b0;
    bit          rndReady = 1'b0;

    pixel_frame_loader dut (
        .clk         (clk),
        .rst         (rst),
        .pix_in      (pix_in),
        .pix_sof     (pix_sof),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .frame_out   (frame_out),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .sof_err     (sof_err),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Stream-level reference: a frame is the last N accepted pixels since a start, raster order.
    task automatic modelAccept(input logic [7:0] p, input bit sof);
        if (sof && modelCnt != 0) begin
            expSofErr++;
            modelFrame = '0;
            modelCnt   = 0;
        end
        modelFrame = {modelFrame[63:0], p};
        modelCnt++;
        if (modelCnt == N) begin
            expQ.push_back(modelFrame);
            modelCnt = 0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] p, input bit sof);
        int tries = 0;
        bit acc;
        pix_in    = p;
        pix_sof   = sof;
        pix_valid = 1'b1;
        forever begin
            acc = pix_ready;
            @(posedge clk);
            if (acc) modelAccept(p, sof);
            @(negedge clk);
            if (acc) break;
            stalls++;
            tries++;
            if (tries > 200) begin
                checks++;
                failures++;
                $display("[TB] FAIL accept_timeout actual=stalled expected=accept");
                break;
            end
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_in    = 8'($urandom);
    endtask

    task automatic sendFrame(input int gapPct, input bit randSof);
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 99) < gapPct) begin
                pix_valid = 1'b0;
                pix_in    = 8'($urandom);
                @(negedge clk);
            end
            applyStimulus(8'($urandom), (i == 0) ? (randSof ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0);
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        frame_ready = 1'b1;
        while ((expQ.size() != 0 || frame_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checkOutput("drain_queue", 72'(expQ.size()), 72'd0);
    endtask

    // Reset is raised mid-cycle so a synchronous clear would still show old values at the check.
    task automatic doReset(input string tag);
        monEn = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput({tag, "_rst_pix_ready"}, 72'(pix_ready), 72'd0);
        checkOutput({tag, "_rst_frame_valid"}, 72'(frame_valid), 72'd0);
        checkOutput({tag, "_rst_frame_out"}, frame_out, 72'd0);
        checkOutput({tag, "_rst_sof_err"}, 72'(sof_err), 72'd0);
        checkOutput({tag, "_rst_frame_cnt"}, 72'(frame_cnt), 72'd0);
        @(negedge clk);
        expQ.delete();
        modelCnt   = 0;
        modelFrame = '0;
        delivered  = 0;
        seenSofErr = 0;
        expSofErr  = 0;
        pix_valid  = 1'b0;
        pix_sof    = 1'b0;
        rst        = 1'b0;
        checkOutput({tag, "_ready_before_edge"}, 72'(pix_ready), 72'd0);
        @(negedge clk);
        checkOutput({tag, "_ready_rise"}, 72'(pix_ready), 72'd1);
        monEn = 1'b1;
    endtask

    // Monitor: pops the scoreboard on each delivery and tracks sof_err pulses.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!monEn) begin
                cntPending  = 1'b0;
                prevSof     = 1'b0;
                prevValid   = 1'b0;
                prevDeliver = 1'b0;
                continue;
            end
            if (cntPending) begin
                checkOutput("frame_cnt", 72'(frame_cnt), 72'(delivered % 65536));
                cntPending = 1'b0;
            end
            if (prevValid && !prevDeliver) checkOutput("valid_held", 72'(frame_valid), 72'd1);
            if (sof_err) begin
                seenSofErr++;
                checkOutput("sof_pulse_width", 72'(prevSof), 72'd0);
            end
            prevSof     = sof_err;
            prevValid   = frame_valid;
            prevDeliver = frame_valid && frame_ready;
            if (prevDeliver) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_frame actual=0x%0h expected=none", frame_out);
                end else begin
                    checkOutput("frame_data", frame_out, expQ.pop_front());
                end
                lastFrame = frame_out;
                delivered++;
                cntPending = 1'b1;
                if (t6Phase) deliverCyc.push_back(cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0;
        @(negedge clk);
        doReset("t0");

        // Known raster 0x10..0x90
        frame_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) checkOutput("t1_not_early", 72'(frame_valid), 72'd0);
            applyStimulus(8'((i + 1) * 16), i == 0);
        end
        checkOutput("t1_latency_valid", 72'(frame_valid), 72'd1);
        checkOutput("t1_frame", frame_out, 72'h102030405060708090);
        waitDrain();
        checkOutput("t1_frame_cnt", 72'(frame_cnt), 72'd1);

        // Back-pressure on the output
        frame_ready = 1'b0;
        sendFrame(0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            checkOutput("t2_valid_held", 72'(frame_valid), 72'd1);
`ifdef LOADER_DBUF_EN
            checkOutput("t2_ready_in_hold", 72'(pix_ready), 72'd1);
`else
            checkOutput("t2_ready_in_hold", 72'(pix_ready), 72'd0);
`endif
            if (expQ.size() > 0) begin
                checkOutput("t2_frame_stable", frame_out, expQ[0]);
            end else begin
                checks++;
                failures++;
                $display("[TB] FAIL t2_expected_frame actual=empty expected=one_frame");
            end
            @(negedge clk);
        end
        frame_ready = 1'b1;
        @(negedge clk);
        checkOutput("t2_valid_cleared", 72'(frame_valid), 72'd0);
        checkOutput("t2_ready_back", 72'(pix_ready), 72'd1);
        checkOutput("t2_frame_cnt", 72'(frame_cnt), 72'd2);

        // Early SOF resync after four pixels
        d0 = delivered;
        for (int i = 0; i < 4; i++) applyStimulus(8'($urandom), i == 0);
        applyStimulus(8'hAA, 1'b1);
        for (int i = 0; i < N - 1; i++) applyStimulus(8'($urandom), 1'b0);
        waitDrain();
        checkOutput("t3_frames", 72'(delivered - d0), 72'd1);
        checkOutput("t3_slot0", 72'(lastFrame[71:64]), 72'hAA);
        checkOutput("t3_sof_err_count", 72'(seenSofErr), 72'(expSofErr));

        // Reset mid-fill and mid-hold
        for (int i = 0; i < 6; i++) applyStimulus(8'($urandom), i == 0);
        doReset("t4_fill");
        sendFrame(0, 1'b0);
        waitDrain();
        checkOutput("t4_cnt_after_fill_reset", 72'(frame_cnt), 72'd1);
        frame_ready = 1'b0;
        sendFrame(0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("t4_in_hold", 72'(frame_valid), 72'd1);
        doReset("t4_hold");
        frame_ready = 1'b1;
        sendFrame(0, 1'b0);
        waitDrain();
        checkOutput("t4_cnt_after_hold_reset", 72'(frame_cnt), 72'd1);

        // Random input gaps and random output back-pressure
        d0 = delivered;
        rndReady = 1'b1;
        fork
            begin
                while (rndReady) begin
                    @(negedge clk);
                    if (rndReady) frame_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int f = 0; f < 6; f++) sendFrame(50, 1'b1);
        rndReady = 1'b0;
        @(negedge clk);
        waitDrain();
        checkOutput("t5_frames", 72'(delivered - d0), 72'd6);
        checkOutput("t5_sof_err_count", 72'(seenSofErr), 72'(expSofErr));

        // Three back-to-back frames with the consumer always ready
        doReset("t6");
        frame_ready = 1'b1;
        stalls = 0;
        deliverCyc.delete();
        t6Phase = 1'b1;
        for (int f = 0; f < 3; f++) sendFrame(0, 1'b0);
        waitDrain();
        t6Phase = 1'b0;
        checkOutput("t6_frame_cnt", 72'(frame_cnt), 72'd3);
`ifdef LOADER_DBUF_EN
        checkOutput("t6_no_stall", 72'(stalls), 72'd0);
        checkOutput("t6_deliveries", 72'(deliverCyc.size()), 72'd3);
        if (deliverCyc.size() == 3) begin
            checkOutput("t6_period_a", 72'(deliverCyc[1] - deliverCyc[0]), 72'd9);
            checkOutput("t6_period_b", 72'(deliverCyc[2] - deliverCyc[1]), 72'd9);
        end
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
